tm_feedback_gen: RTL and testbench
==================================

Name: tm_feedback_gen

Overview:
- Training-path stage directly downstream of the clause-sum/threshold decision stage.
- Consumes one sample's positive/negative clause output vectors plus the target label, and computes the clamped class vote.
- Emits a serial per-clause stream of Tsetlin feedback selections (none / Type I / Type II) to the automaton update logic.
- Selection randomness comes from an internal LFSR.

Parameters:
- NCLAUSE, 10, clauses per polarity; the stream carries 2*NCLAUSE beats.
- T, 4, vote clamp threshold; 1..(2^14-1).
- LFSR_SEED, 16'hACE1, nonzero LFSR reset value.

Ports:
- clk  in  1  clock; everything is rising-edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  sample offered.
- in_ready  out  1  block can accept a sample (high only in IDLE).
- pos_clause  in  NCLAUSE  positive-polarity clause outputs.
- neg_clause  in  NCLAUSE  negative-polarity clause outputs.
- target  in  1  label y for this class.
- class_sum  out  signed $clog2(NCLAUSE+1)+2  clamped vote; held from SUM to end of EMIT.
- fb_valid  out  1  feedback beat valid.
- fb_ready  in  1  consumer accepts beat.
- fb_index  out  $clog2(NCLAUSE)  clause index within polarity.
- fb_polarity  out  1  0 = positive clause, 1 = negative clause.
- fb_type  out  2  00 none, 01 Type I, 10 Type II; 11 never driven.
- fb_last  out  1  high on the final beat (index NCLAUSE-1, polarity 1).

Behaviour:
- Reset (rst=1 at an edge) applies in any state, including mid-EMIT. Result:
  - state IDLE; in_ready=1; fb_valid, fb_index, fb_polarity, fb_type, fb_last and class_sum all 0.
  - LFSR = LFSR_SEED; any partially emitted stream is abandoned.
- IDLE: on in_valid && in_ready, register pos_clause, neg_clause and target, then go to SUM. in_ready drops the next cycle.
- SUM (exactly 1 cycle):
  - v = popcount(pos) - popcount(neg), signed, no overflow possible at the given width.
  - class_sum = clamp(v, -T, +T).
  - p = T - class_sum if target=1, else T + class_sum; range 0..2T.
  - Go to EMIT with fb_valid=1 on the first beat, so the first beat appears 2 cycles after the accept edge.
- EMIT beat order:
  - Positive clauses first, index 0..NCLAUSE-1, then negative clauses 0..NCLAUSE-1.
  - fb_last marks the final beat.
- Per-beat selection:
  - r = (lfsr[15:0] * 2T) >> 16, giving a value in 0..2T-1.
  - Selected when r < p; so p=2T always selects and p=0 never selects.
- Type mapping when selected:
  - target=1: positive clause -> Type I, negative clause -> Type II.
  - target=0: positive clause -> Type II, negative clause -> Type I.
  - Not selected -> 00.
- Handshake:
  - While fb_valid && !fb_ready, all fb_* outputs stay stable and the LFSR holds.
  - On fb_valid && fb_ready, the LFSR steps once and the next beat is presented the following cycle (1 beat/cycle under full throughput).
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400). It steps only on accepted beats.
- After the fb_last beat is accepted: fb_valid=0, return to IDLE, in_ready=1 next cycle. class_sum keeps its value until the next SUM.
- in_valid while not in IDLE is ignored; no sample is captured.
- Inputs are sampled only at accept, so later changes to the clause vectors do not affect the stream in flight.

Decomposition:
- Shared package tm_pkg holds:
  - the fb_type encodings FB_NONE=2'b00, FB_TYPE1=2'b01, FB_TYPE2=2'b10;
  - the default LFSR polynomial mask;
  - the state enum IDLE/SUM/EMIT.
- One natural sub-module: tm_lfsr16, with clk, rst, step, seed parameter and 16-bit state out. It is reusable by clause-level update logic.
- Popcount stays inline.

Test Plan:
- T=4, N=10, pos=10'h3FF, neg=0, target=1 -> class_sum=+4, p=0, 20 beats all fb_type=00, fb_last on beat 20.
- Same vectors, target=0 -> p=8 -> beats 1-10 (pos) all Type II, beats 11-20 (neg) all Type I.
- pos=10'h007, neg=10'h01F, target=1 -> class_sum=-2, p=6. Each beat's type matches a reference model of r<6 stepped from seed 16'hACE1.
- Backpressure: fb_ready low 3 cycles on beat 5 -> beat 5 fields stable; sequence identical to the no-stall run; in_valid pulsed during EMIT is ignored.
- Reset at beat 7 of EMIT -> next cycle all outputs 0, in_ready=1. Rerunning the same sample reproduces the beat-1 type from seed.
- Back-to-back samples with in_valid held high -> second accept occurs the cycle after the first stream's fb_last is accepted; its first beat follows 2 cycles later.

Source files
------------

// File: rtl/tm_pkg.sv
// Shared definitions for the Tsetlin-machine training path.
//   FB_*               feedback selection encodings carried on fb_type
//   LFSR_MASK_DEFAULT  Galois mask for x^16+x^14+x^13+x^11+1
//   state_t            control states of the feedback generator
package tm_pkg;

  localparam logic [1:0] FB_NONE  = 2'b00;
  localparam logic [1:0] FB_TYPE1 = 2'b01;
  localparam logic [1:0] FB_TYPE2 = 2'b10;

  localparam logic [15:0] LFSR_MASK_DEFAULT = 16'hB400;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUM  = 2'd1,
    EMIT = 2'd2
  } state_t;

endpackage

// File: rtl/tm_feedback_gen_if.sv
// Bus bundles for the feedback generator.
//   tm_sample_if : one training sample (clause vectors + label) with
//                  valid/ready; master = upstream producer, slave = consumer.
//   tm_fb_if     : serial per-clause feedback stream with valid/ready;
//                  master = generator, slave = automaton update logic.
interface tm_sample_if #(
  parameter int NCLAUSE = 10
);
  logic               in_valid;
  logic               in_ready;
  logic [NCLAUSE-1:0] pos_clause;
  logic [NCLAUSE-1:0] neg_clause;
  logic               target;

  modport master (output in_valid, pos_clause, neg_clause, target,
                  input  in_ready);
  modport slave  (input  in_valid, pos_clause, neg_clause, target,
                  output in_ready);
endinterface

interface tm_fb_if #(
  parameter int NCLAUSE = 10
);
  localparam int IW = (NCLAUSE > 1) ? $clog2(NCLAUSE) : 1;

  logic          fb_valid;
  logic          fb_ready;
  logic [IW-1:0] fb_index;
  logic          fb_polarity;
  logic [1:0]    fb_type;
  logic          fb_last;

  modport master (output fb_valid, fb_index, fb_polarity, fb_type, fb_last,
                  input  fb_ready);
  modport slave  (input  fb_valid, fb_index, fb_polarity, fb_type, fb_last,
                  output fb_ready);
endinterface

// File: rtl/tm_lfsr16.sv
// 16-bit Galois LFSR that advances only when step is high.
//   clk, rst : clock and synchronous active-high reset (loads SEED)
//   step     : advance one position this cycle
//   state    : current register contents
module tm_lfsr16
  import tm_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1,
  parameter logic [15:0] MASK = LFSR_MASK_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  output logic [15:0] state
);

  logic [15:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (step) begin
      // Shift right; the bit falling out of the bottom folds the taps back in.
      state_d = (state_q >> 1) ^ (state_q[0] ? MASK : 16'h0000);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= SEED;
    else     state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/tm_feedback_gen.sv
// Tsetlin feedback generator: takes one sample's clause outputs and label,
// computes the clamped class vote, then streams one feedback selection per
// clause (positive clauses first, then negative).
//   clk, rst   : clock, synchronous active-high reset
//   smp        : sample input bundle (slave), in_ready high only in IDLE
//   fb         : feedback beat stream (master), one beat per accepted cycle
//   class_sum  : clamped vote, updated in SUM and held until the next SUM
module tm_feedback_gen
  import tm_pkg::*;
#(
  parameter int          NCLAUSE   = 10,
  parameter int          T         = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  tm_sample_if.slave                             smp,
  tm_fb_if.master                                fb,
  output logic signed [$clog2(NCLAUSE+1)+1:0]    class_sum
);

  localparam int CSW = $clog2(NCLAUSE + 1) + 2;
  localparam int IW  = (NCLAUSE > 1) ? $clog2(NCLAUSE) : 1;
  localparam int VW  = 17;  // holds +/-(2^14-1) thresholds and 2T without overflow
  localparam int PW  = 16;

  localparam logic signed [VW-1:0] T_W      = VW'(T);
  localparam logic [PW-1:0]        T2       = PW'(2 * T);
  localparam logic [IW-1:0]        IDX_LAST = IW'(NCLAUSE - 1);

  state_t                state_q, state_d;
  logic [NCLAUSE-1:0]    pos_q, pos_d;
  logic [NCLAUSE-1:0]    neg_q, neg_d;
  logic                  target_q, target_d;
  logic signed [CSW-1:0] class_sum_q, class_sum_d;
  logic [PW-1:0]         p_q, p_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  pol_q, pol_d;

  logic [15:0]           lfsr;
  logic                  lfsr_step;
  logic signed [VW-1:0]  vote_w, clamp_w, p_sum;
  logic [PW-1:0]         r;
  logic                  sel;
  logic                  is_last;
  logic                  emit;

  tm_lfsr16 #(
    .SEED (LFSR_SEED),
    .MASK (LFSR_MASK_DEFAULT)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .step  (lfsr_step),
    .state (lfsr)
  );

  // Vote, clamp and selection probability from the captured sample.
  always_comb begin
    vote_w = VW'($countones(pos_q)) - VW'($countones(neg_q));
    if (vote_w > T_W)       clamp_w = T_W;
    else if (vote_w < -T_W) clamp_w = -T_W;
    else                    clamp_w = vote_w;
    p_sum = target_q ? (T_W - clamp_w) : (T_W + clamp_w);
  end

  // Scale the LFSR into 0..2T-1; the beat is selected when it falls below p.
  assign r   = PW'((32'(lfsr) * 32'(T2)) >> 16);
  assign sel = (r < p_q);

  assign emit    = (state_q == EMIT);
  assign is_last = pol_q && (idx_q == IDX_LAST);

  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    neg_d       = neg_q;
    target_d    = target_q;
    class_sum_d = class_sum_q;
    p_d         = p_q;
    idx_d       = idx_q;
    pol_d       = pol_q;
    lfsr_step   = 1'b0;

    smp.in_ready   = (state_q == IDLE);
    fb.fb_valid    = emit;
    fb.fb_index    = emit ? idx_q : '0;
    fb.fb_polarity = emit && pol_q;
    fb.fb_last     = emit && is_last;
    fb.fb_type     = FB_NONE;
    // Positive clauses reinforce the label, negative clauses oppose it.
    if (emit && sel) fb.fb_type = (target_q == pol_q) ? FB_TYPE2 : FB_TYPE1;

    case (state_q)
      IDLE: begin
        if (smp.in_valid) begin
          pos_d    = smp.pos_clause;
          neg_d    = smp.neg_clause;
          target_d = smp.target;
          state_d  = SUM;
        end
      end
      SUM: begin
        class_sum_d = CSW'(clamp_w);
        p_d         = PW'(p_sum);
        idx_d       = '0;
        pol_d       = 1'b0;
        state_d     = EMIT;
      end
      EMIT: begin
        if (fb.fb_ready) begin
          lfsr_step = 1'b1;
          if (is_last) begin
            idx_d   = '0;
            pol_d   = 1'b0;
            state_d = IDLE;
          end else if (idx_q == IDX_LAST) begin
            idx_d = '0;
            pol_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pos_q       <= '0;
      neg_q       <= '0;
      target_q    <= 1'b0;
      class_sum_q <= '0;
      p_q         <= '0;
      idx_q       <= '0;
      pol_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      neg_q       <= neg_d;
      target_q    <= target_d;
      class_sum_q <= class_sum_d;
      p_q         <= p_d;
      idx_q       <= idx_d;
      pol_q       <= pol_d;
    end
  end

  assign class_sum = class_sum_q;

endmodule

// File: tb/tb_tm_feedback_gen.sv
// Scoreboard bench for tm_feedback_gen: every accepted sample pushes its 20
// expected beats (from an independent vote/LFSR model); every accepted beat
// pops and compares.
module tb_tm_feedback_gen;
  import tm_pkg::*;

  localparam int          N    = 10;
  localparam int          T    = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic signed [5:0] class_sum;

  tm_sample_if #(.NCLAUSE(N)) smp ();
  tm_fb_if     #(.NCLAUSE(N)) fbi ();

  tm_feedback_gen #(
    .NCLAUSE   (N),
    .T         (T),
    .LFSR_SEED (SEED)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .smp       (smp),
    .fb        (fbi),
    .class_sum (class_sum)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int pol;
    int typ;
    int last;
    int cs;
  } beat_t;

  beat_t       exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [15:0] m_lfsr = SEED;
  int          acc_cnt = 0;
  int          done_cnt = 0;
  int          beat_cnt = 0;
  int          stream_beats = 0;
  int          acc_edge = 0;
  int          last_edge = -100;
  int          acc_gap = 0;
  int          first_lat = 0;

  task automatic chk(input string tag, input logic signed [31:0] got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  // Expected beats for one accepted sample, advancing the model LFSR per beat.
  task automatic push_sample(input logic [N-1:0] pos, input logic [N-1:0] neg, input logic tgt);
    int v, cs, p, r, typ;
    beat_t e;
    v  = $countones(pos) - $countones(neg);
    cs = (v > T) ? T : ((v < -T) ? -T : v);
    p  = tgt ? (T - cs) : (T + cs);
    for (int pol = 0; pol < 2; pol++) begin
      for (int i = 0; i < N; i++) begin
        r   = (int'(m_lfsr) * 2 * T) >>> 16;
        typ = (r < p) ? (((pol == 0) == tgt) ? 1 : 2) : 0;
        e.idx  = i;
        e.pol  = pol;
        e.typ  = typ;
        e.last = (pol == 1 && i == N - 1) ? 1 : 0;
        e.cs   = cs;
        exp_q.push_back(e);
        m_lfsr = lfsr_next(m_lfsr);
      end
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: handshakes seen here complete at the following rising edge (cyc+1).
  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      exp_q.delete();
      m_lfsr   = SEED;
      beat_cnt = 0;
    end else begin
      if (smp.in_valid && smp.in_ready) begin
        acc_cnt++;
        acc_edge = cyc + 1;
        acc_gap  = acc_edge - last_edge;
        push_sample(smp.pos_clause, smp.neg_clause, smp.target);
      end
      if (fbi.fb_valid && fbi.fb_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          $display("beat %0d: idx=%0d pol=%0d type=%0d last=%0d (exp %0d/%0d/%0d/%0d)",
                   beat_cnt + 1, fbi.fb_index, fbi.fb_polarity, fbi.fb_type, fbi.fb_last,
                   e.idx, e.pol, e.typ, e.last);
          chk("fb_index", fbi.fb_index, e.idx);
          chk("fb_polarity", fbi.fb_polarity, e.pol);
          chk("fb_type", fbi.fb_type, e.typ);
          chk("fb_last", fbi.fb_last, e.last);
          if (beat_cnt == 0) begin
            first_lat = cyc + 1 - acc_edge;
            chk("class_sum", class_sum, e.cs);
          end
          beat_cnt++;
          if (e.last != 0) begin
            stream_beats = beat_cnt;
            beat_cnt     = 0;
            done_cnt++;
            last_edge    = cyc + 1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic send(input logic [N-1:0] pos, input logic [N-1:0] neg, input logic tgt);
    smp.pos_clause = pos;
    smp.neg_clause = neg;
    smp.target     = tgt;
    smp.in_valid   = 1'b1;
    tick();
    smp.in_valid   = 1'b0;
  endtask

  task automatic wait_done(input int want, input string tag);
    int n = 0;
    while (done_cnt < want && n < 300) begin
      tick();
      n++;
    end
    chk(tag, done_cnt, want);
  endtask

  task automatic wait_beats(input int want, input string tag);
    int n = 0;
    while (beat_cnt < want && n < 100) begin
      tick();
      n++;
    end
    chk(tag, beat_cnt, want);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_in_ready"}, smp.in_ready, 1);
    chk({tag, "_fb_valid"}, fbi.fb_valid, 0);
    chk({tag, "_fb_index"}, fbi.fb_index, 0);
    chk({tag, "_fb_polarity"}, fbi.fb_polarity, 0);
    chk({tag, "_fb_type"}, fbi.fb_type, 0);
    chk({tag, "_fb_last"}, fbi.fb_last, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, acc0, n;
    beat_t e;
    smp.in_valid   = 1'b0;
    smp.pos_clause = '0;
    smp.neg_clause = '0;
    smp.target     = 1'b0;
    fbi.fb_ready   = 1'b1;
    rst            = 1'b1;
    repeat (3) tick();
    check_idle_outputs("reset");
    chk("reset_class_sum", class_sum, 0);
    rst = 1'b0;
    tick();

    // Saturated positive vote, target=1: p=0, nothing selected.
    send(10'h3FF, 10'h000, 1'b1);
    wait_done(1, "t1_done");
    chk("t1_beats", stream_beats, 20);
    chk("t1_first_lat", first_lat, 2);
    chk("t1_qempty", exp_q.size(), 0);
    tick();
    chk("t1_class_sum_held", class_sum, 4);

    // Same vectors, target=0: p=2T, every clause selected.
    send(10'h3FF, 10'h000, 1'b0);
    wait_done(2, "t2_done");
    chk("t2_qempty", exp_q.size(), 0);

    // Mid-range vote from seed: class_sum=-2, p=6.
    pulse_reset();
    send(10'h007, 10'h01F, 1'b1);
    wait_done(3, "t3_done");
    chk("t3_class_sum", class_sum, -2);

    // Backpressure on beat 5 with an ignored in_valid pulse.
    pulse_reset();
    acc0 = acc_cnt;
    send(10'h007, 10'h01F, 1'b1);
    wait_beats(4, "t4_reach_beat5");
    fbi.fb_ready = 1'b0;
    e = exp_q[0];
    for (int k = 0; k < 3; k++) begin
      chk("stall_valid", fbi.fb_valid, 1);
      chk("stall_index", fbi.fb_index, e.idx);
      chk("stall_polarity", fbi.fb_polarity, e.pol);
      chk("stall_type", fbi.fb_type, e.typ);
      if (k == 1) begin
        smp.pos_clause = 10'h3FF;
        smp.neg_clause = 10'h000;
        smp.target     = 1'b0;
        smp.in_valid   = 1'b1;
      end
      tick();
      smp.in_valid = 1'b0;
    end
    fbi.fb_ready = 1'b1;
    wait_done(4, "t4_done");
    repeat (3) tick();
    chk("t4_accepts", acc_cnt - acc0, 1);
    check_idle_outputs("t4_after");

    // Reset while emitting beat 7, then replay from seed.
    base = done_cnt;
    send(10'h007, 10'h01F, 1'b1);
    wait_beats(6, "t5_reach_beat7");
    pulse_reset();
    check_idle_outputs("t5_reset");
    chk("t5_class_sum", class_sum, 0);
    send(10'h007, 10'h01F, 1'b1);
    wait_done(base + 1, "t5_done");

    // Back-to-back samples with in_valid held high.
    base = done_cnt;
    acc0 = acc_cnt;
    smp.pos_clause = 10'h007;
    smp.neg_clause = 10'h01F;
    smp.target     = 1'b1;
    smp.in_valid   = 1'b1;
    tick();
    smp.pos_clause = 10'h3FF;
    smp.neg_clause = 10'h000;
    smp.target     = 1'b0;
    n = 0;
    while (acc_cnt < acc0 + 2 && n < 300) begin
      tick();
      n++;
    end
    smp.in_valid = 1'b0;
    chk("t6_accepts", acc_cnt - acc0, 2);
    wait_done(base + 2, "t6_done");
    chk("t6_accept_gap", acc_gap, 1);
    chk("t6_first_lat", first_lat, 2);
    chk("t6_qempty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
